tick_event_counter: RTL and testbench

Avalon-MM slave (16-bit data, 3-bit word address) that consumes the tick/irq output of the system interval timer and counts tick events into a 32-bit uptime counter. Ticks pass through a programmable prescaler before the counter increments. A 32-bit compare register raises a maskable alarm interrupt. An atomic snapshot mechanism lets software read the 32-bit count as two 16-bit halves. Sits between the system tick timer and the CPU interrupt controller.

---
 rtl/tick_event_counter_pkg.sv | 31 +++
 rtl/tick_prescaler.sv | 48 ++++
 rtl/tick_event_counter.sv | 132 +++++++++++++
 tb/tb_tick_event_counter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_event_counter_pkg.sv
// Shared register map, bit positions and widths for the tick event counter.
// No logic of its own; imported by the counter top and its prescaler.
package tick_event_counter_pkg;

   localparam int DATA_W  = 16;
   localparam int COUNT_W = 32;

   localparam logic [2:0] ADDR_STATUS   = 3'd0;
   localparam logic [2:0] ADDR_CONTROL  = 3'd1;
   localparam logic [2:0] ADDR_PRESCALE = 3'd2;
   localparam logic [2:0] ADDR_SNAP_L   = 3'd3;
   localparam logic [2:0] ADDR_SNAP_H   = 3'd4;
   localparam logic [2:0] ADDR_CMP_L    = 3'd5;
   localparam logic [2:0] ADDR_CMP_H    = 3'd6;

   localparam int ST_ALARM = 0;
   localparam int ST_RUN   = 1;
   localparam int ST_OVF   = 2;

   localparam int CT_RUN     = 0;
   localparam int CT_IRQEN   = 1;
   localparam int CT_AUTOCLR = 2;
   localparam int CT_CLEAR   = 3;

   typedef struct packed {
      logic auto_clear;
      logic irq_en;
      logic run;
   } ctrl_t;

endpackage

// File: rtl/tick_prescaler.sv
// Rising-edge detect on tick_in and divide-by-(prescale+1); inc is a same-cycle pulse.
// Always accepts input; clear or a prescale write restarts the divider and drops that edge.
module tick_prescaler
   import tick_event_counter_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              tick_in,
   input  logic              run,
   input  logic [DATA_W-1:0] prescale,
   input  logic              prescale_wr,
   input  logic              clear,
   output logic              inc
);

   logic              tick_d_q, tick_d_d;
   logic [DATA_W-1:0] pre_cnt_q, pre_cnt_d;
   logic              tick_edge;

   always_comb begin
      tick_d_d  = tick_in;
      tick_edge = tick_in & ~tick_d_q;
      pre_cnt_d = pre_cnt_q;
      inc       = 1'b0;
      // Edge history keeps tracking even while stopped, so a held level never double-counts.
      if (clear || prescale_wr) begin
         pre_cnt_d = '0;
      end else if (tick_edge && run) begin
         if (pre_cnt_q == prescale) begin
            pre_cnt_d = '0;
            inc       = 1'b1;
         end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tick_d_q  <= 1'b0;
         pre_cnt_q <= '0;
      end else begin
         tick_d_q  <= tick_d_d;
         pre_cnt_q <= pre_cnt_d;
      end
   end

endmodule

// File: rtl/tick_event_counter.sv
// Avalon-MM uptime counter fed by timer ticks, with compare alarm irq and atomic 32-bit snapshot.
// Read latency 1 cycle, irq 1 cycle after alarm; slave is always ready (no waitrequest).
module tick_event_counter
   import tick_event_counter_pkg::*;
#(
   parameter logic [DATA_W-1:0]  PRESCALE_RESET = 16'd0,
   parameter logic [2:0]         CONTROL_RESET  = 3'b000,
   parameter logic [COUNT_W-1:0] COMPARE_RESET  = 32'hFFFF_FFFF
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              tick_in,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] readdata,
   output logic              irq
);

   logic [COUNT_W-1:0] count_q, count_d;
   logic [COUNT_W-1:0] snapshot_q, snapshot_d;
   logic [COUNT_W-1:0] compare_q, compare_d;
   logic [DATA_W-1:0]  prescale_q, prescale_d;
   ctrl_t              control_q, control_d;
   logic               alarm_pending_q, alarm_pending_d;
   logic               overflow_q, overflow_d;
   logic               irq_q, irq_d;
   logic [DATA_W-1:0]  readdata_q, readdata_d;

   logic               wr_en, wr_status, wr_control, wr_prescale, wr_snap, wr_cmp_l, wr_cmp_h;
   logic               clear_strobe, inc;
   logic [COUNT_W-1:0] count_inc;
   logic               alarm_set, ovf_set;

   assign wr_en        = chipselect & ~write_n;
   assign wr_status    = wr_en & (address == ADDR_STATUS);
   assign wr_control   = wr_en & (address == ADDR_CONTROL);
   assign wr_prescale  = wr_en & (address == ADDR_PRESCALE);
   assign wr_snap      = wr_en & ((address == ADDR_SNAP_L) | (address == ADDR_SNAP_H));
   assign wr_cmp_l     = wr_en & (address == ADDR_CMP_L);
   assign wr_cmp_h     = wr_en & (address == ADDR_CMP_H);
   assign clear_strobe = wr_control & writedata[CT_CLEAR];
   assign count_inc    = count_q + 1'b1;

   tick_prescaler u_prescaler (
      .clk         (clk),
      .reset_n     (reset_n),
      .tick_in     (tick_in),
      .run         (control_q.run),
      .prescale    (prescale_q),
      .prescale_wr (wr_prescale),
      .clear       (clear_strobe),
      .inc         (inc)
   );

   always_comb begin
      count_d         = count_q;
      snapshot_d      = snapshot_q;
      compare_d       = compare_q;
      prescale_d      = prescale_q;
      control_d       = control_q;
      alarm_pending_d = alarm_pending_q;
      overflow_d      = overflow_q;
      alarm_set       = 1'b0;
      ovf_set         = 1'b0;

      // Alarm only fires on an increment, never on a compare write that happens to match.
      if (clear_strobe) begin
         count_d = '0;
      end else if (inc) begin
         alarm_set = (count_inc == compare_q);
         ovf_set   = (count_q == {COUNT_W{1'b1}});
         count_d   = (alarm_set && control_q.auto_clear) ? '0 : count_inc;
      end

      if (wr_snap) snapshot_d = count_q;

      if (wr_status && writedata[ST_ALARM]) alarm_pending_d = 1'b0;
      if (wr_status && writedata[ST_OVF])   overflow_d      = 1'b0;
      if (alarm_set) alarm_pending_d = 1'b1;
      if (ovf_set)   overflow_d      = 1'b1;

      if (wr_control)  control_d              = ctrl_t'(writedata[CT_AUTOCLR:CT_RUN]);
      if (wr_prescale) prescale_d             = writedata;
      if (wr_cmp_l)    compare_d[DATA_W-1:0]  = writedata;
      if (wr_cmp_h)    compare_d[COUNT_W-1:DATA_W] = writedata;

      irq_d = alarm_pending_q & control_q.irq_en;

      readdata_d = '0;
      case (address)
         ADDR_STATUS:   readdata_d = {13'b0, overflow_q, control_q.run, alarm_pending_q};
         ADDR_CONTROL:  readdata_d = {13'b0, control_q};
         ADDR_PRESCALE: readdata_d = prescale_q;
         ADDR_SNAP_L:   readdata_d = snapshot_q[DATA_W-1:0];
         ADDR_SNAP_H:   readdata_d = snapshot_q[COUNT_W-1:DATA_W];
         ADDR_CMP_L:    readdata_d = compare_q[DATA_W-1:0];
         ADDR_CMP_H:    readdata_d = compare_q[COUNT_W-1:DATA_W];
         default:       readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_q         <= '0;
         snapshot_q      <= '0;
         compare_q       <= COMPARE_RESET;
         prescale_q      <= PRESCALE_RESET;
         control_q       <= ctrl_t'(CONTROL_RESET);
         alarm_pending_q <= 1'b0;
         overflow_q      <= 1'b0;
         irq_q           <= 1'b0;
         readdata_q      <= '0;
      end else begin
         count_q         <= count_d;
         snapshot_q      <= snapshot_d;
         compare_q       <= compare_d;
         prescale_q      <= prescale_d;
         control_q       <= control_d;
         alarm_pending_q <= alarm_pending_d;
         overflow_q      <= overflow_d;
         irq_q           <= irq_d;
         readdata_q      <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_tick_event_counter.sv
// Bench for tick_event_counter: cycle model checked every cycle plus literal register reads.
module tb_tick_event_counter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        tick_in = 1'b0;
   logic [2:0]  address = 3'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [15:0] writedata = 16'h0;
   logic [15:0] readdata;
   logic        irq;

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   tick_event_counter dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .tick_in    (tick_in),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   // Behavioural model: state as the register map describes it, divider kept as an edge tally.
   logic [31:0] m_count, m_snap, m_cmp, m_nxt;
   logic [15:0] m_prescale, m_rd, m_rd_n;
   logic [2:0]  m_ctrl;
   logic        m_alarm, m_ovf, m_irq, m_irq_n, m_tickd;
   logic        m_wr, m_clr, m_pwr, m_fire, m_set_a, m_set_o;
   int          m_edges;

   function automatic logic [15:0] m_read(input logic [2:0] a);
      case (a)
         3'd0:    return {13'b0, m_ovf, m_ctrl[0], m_alarm};
         3'd1:    return {13'b0, m_ctrl};
         3'd2:    return m_prescale;
         3'd3:    return m_snap[15:0];
         3'd4:    return m_snap[31:16];
         3'd5:    return m_cmp[15:0];
         3'd6:    return m_cmp[31:16];
         default: return 16'h0;
      endcase
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         if (!reset_n) begin
            m_count = 0; m_snap = 0; m_cmp = 32'hFFFF_FFFF; m_prescale = 0; m_ctrl = 0;
            m_alarm = 0; m_ovf = 0; m_irq = 0; m_tickd = 0; m_rd = 0; m_edges = 0;
         end else begin
            m_rd_n  = m_read(address);
            m_irq_n = m_alarm && m_ctrl[1];
            m_wr    = chipselect && !write_n;
            m_clr   = m_wr && address == 3'd1 && writedata[3];
            m_pwr   = m_wr && address == 3'd2;
            m_fire  = 1'b0;
            if (m_clr || m_pwr) m_edges = 0;
            else if (tick_in && !m_tickd && m_ctrl[0]) begin
               m_edges = m_edges + 1;
               if (m_edges > int'(m_prescale)) begin
                  m_fire  = 1'b1;
                  m_edges = 0;
               end
            end
            m_tickd = tick_in;
            if (m_wr && (address == 3'd3 || address == 3'd4)) m_snap = m_count;
            m_set_a = 1'b0;
            m_set_o = 1'b0;
            if (m_clr) m_count = 0;
            else if (m_fire) begin
               m_nxt   = m_count + 32'd1;
               m_set_o = (m_count == 32'hFFFF_FFFF);
               m_set_a = (m_nxt == m_cmp);
               m_count = (m_set_a && m_ctrl[2]) ? 32'd0 : m_nxt;
            end
            if (m_wr && address == 3'd0) begin
               if (writedata[0]) m_alarm = 1'b0;
               if (writedata[2]) m_ovf = 1'b0;
            end
            if (m_set_a) m_alarm = 1'b1;
            if (m_set_o) m_ovf = 1'b1;
            if (m_wr && address == 3'd1) m_ctrl = writedata[2:0];
            if (m_pwr) m_prescale = writedata;
            if (m_wr && address == 3'd5) m_cmp[15:0] = writedata;
            if (m_wr && address == 3'd6) m_cmp[31:16] = writedata;
            m_irq = m_irq_n;
            m_rd  = m_rd_n;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("model_readdata", {16'h0, readdata}, {16'h0, m_rd});
            chk("model_irq", {31'h0, irq}, {31'h0, m_irq});
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic wr_tick(input logic [2:0] a, input logic [15:0] d);
      tick_in = 1'b1;
      wr(a, d);
      tick_in = 1'b0;
      @(negedge clk);
   endtask

   task automatic rd_chk(input string name, input logic [2:0] a, input logic [15:0] exp);
      address = a;
      @(negedge clk);
      chk(name, {16'h0, readdata}, {16'h0, exp});
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         tick_in = 1'b1;
         @(negedge clk);
         tick_in = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic preload(input logic [31:0] v);
      force dut.count_d = v;
      m_count = v;
      @(negedge clk);
      release dut.count_d;
   endtask

   initial begin
      // Reset defaults
      idle(2);
      reset_n = 1'b1;
      chk_en  = 1'b1;
      rd_chk("rst_control", 3'd1, 16'h0000);
      rd_chk("rst_prescale", 3'd2, 16'h0000);
      rd_chk("rst_cmp_l", 3'd5, 16'hFFFF);
      rd_chk("rst_cmp_h", 3'd6, 16'hFFFF);
      rd_chk("rst_status", 3'd0, 16'h0000);
      chk("rst_irq", {31'h0, irq}, 32'h0);

      // Prescale 2: nine pulses give three counts, a long level is one edge
      wr(3'd2, 16'd2);
      wr(3'd1, 16'h0001);
      tick(9);
      wr(3'd3, 16'h0);
      rd_chk("pre_snap_h", 3'd4, 16'h0000);
      rd_chk("pre_snap_l", 3'd3, 16'h0003);
      tick_in = 1'b1;
      idle(10);
      tick_in = 1'b0;
      idle(1);
      tick(2);
      wr(3'd4, 16'h0);
      rd_chk("level_one_edge", 3'd3, 16'h0004);

      // Alarm at compare 5 with irq enabled, then W1C
      wr(3'd1, 16'h0008);
      wr(3'd2, 16'd0);
      wr(3'd5, 16'd5);
      wr(3'd6, 16'd0);
      wr(3'd1, 16'h0003);
      tick(5);
      chk("alarm_irq_high", {31'h0, irq}, 32'h1);
      rd_chk("alarm_status", 3'd0, 16'h0003);
      wr(3'd0, 16'h0001);
      chk("w1c_irq_lag", {31'h0, irq}, 32'h1);
      idle(1);
      chk("w1c_irq_low", {31'h0, irq}, 32'h0);

      // Auto-clear restarts the count on a match
      wr(3'd1, 16'h0008);
      wr(3'd1, 16'h0007);
      tick(5);
      wr(3'd3, 16'h0);
      rd_chk("autoclr_count", 3'd3, 16'h0000);
      rd_chk("autoclr_status", 3'd0, 16'h0003);
      tick(1);
      wr(3'd3, 16'h0);
      rd_chk("autoclr_restart", 3'd3, 16'h0001);
      wr(3'd0, 16'h0001);
      wr(3'd1, 16'h0001);

      // Overflow: wrap to zero sets overflow but no alarm
      wr(3'd5, 16'hFFFF);
      wr(3'd6, 16'hFFFF);
      preload(32'hFFFF_FFFF);
      tick(1);
      wr(3'd3, 16'h0);
      rd_chk("ovf_snap_l", 3'd3, 16'h0000);
      rd_chk("ovf_snap_h", 3'd4, 16'h0000);
      rd_chk("ovf_status", 3'd0, 16'h0006);
      wr(3'd0, 16'h0004);
      rd_chk("ovf_w1c", 3'd0, 16'h0002);

      // Clear strobe beats a simultaneous edge and restarts the divider
      wr(3'd2, 16'd1);
      tick(1);
      wr_tick(3'd1, 16'h0009);
      tick(1);
      wr(3'd3, 16'h0);
      rd_chk("clr_wins", 3'd3, 16'h0000);
      tick(1);
      wr(3'd3, 16'h0);
      rd_chk("clr_pre_reset", 3'd3, 16'h0001);

      // Set beats W1C; prescale write drops an edge; snapshot takes pre-increment value
      wr(3'd2, 16'd0);
      wr(3'd1, 16'h0008);
      wr(3'd5, 16'd2);
      wr(3'd6, 16'd0);
      wr(3'd1, 16'h0001);
      tick(2);
      wr(3'd0, 16'h0001);
      rd_chk("w1c_before_set", 3'd0, 16'h0002);
      wr(3'd5, 16'd3);
      wr_tick(3'd0, 16'h0001);
      rd_chk("set_beats_w1c", 3'd0, 16'h0003);
      wr_tick(3'd2, 16'd0);
      wr(3'd3, 16'h0);
      rd_chk("pwr_drops_edge", 3'd3, 16'h0003);
      wr_tick(3'd3, 16'h0);
      rd_chk("snap_pre_inc", 3'd3, 16'h0003);
      wr(3'd4, 16'h0);
      rd_chk("snap_post_inc", 3'd3, 16'h0004);

      // Reset mid-operation with irq asserted
      wr(3'd0, 16'h0001);
      wr(3'd5, 16'h1234);
      wr(3'd6, 16'h0000);
      wr(3'd1, 16'h0003);
      preload(32'h0000_1233);
      tick(1);
      chk("pre_reset_irq", {31'h0, irq}, 32'h1);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("reset_irq_low", {31'h0, irq}, 32'h0);
      rd_chk("reset_cmp_l", 3'd5, 16'hFFFF);
      rd_chk("reset_cmp_h", 3'd6, 16'hFFFF);
      rd_chk("reset_control", 3'd1, 16'h0000);
      wr(3'd3, 16'h0);
      rd_chk("reset_count", 3'd3, 16'h0000);

      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
